ecc_enc_dec_core: RTL and testbench

Datapath stage directly downstream of the APB register block. On each new `start` it latches the CTRL, DATA_IN, CODEWORD_WIDTH and NOISE words and runs one of three operations: encode, decode, or full channel (encode, inject noise, decode). The code is extended Hamming (SECDED) at 8, 16 or 32-bit codeword width. Syndrome and parity are accumulated bit-serially, one codeword position per cycle. Results are held on `data_out`/`num_of_errors` until the next operation completes.

---
 rtl/ecc_enc_dec_core_if.sv | 28 ++
 rtl/ecc_enc_dec_core.sv | 292 +++++++++++++++++++++++++++++
 tb/tb_ecc_enc_dec_core.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ecc_enc_dec_core_if.sv
// rtl/ecc_enc_dec_core_if.sv - request/result bundle between the APB register block and the ECC core

interface ecc_enc_dec_core_if #(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  start;
    logic [AMBA_WORD-1:0]  CTRL;
    logic [AMBA_WORD-1:0]  DATA_IN;
    logic [AMBA_WORD-1:0]  CODEWORD_WIDTH;
    logic [AMBA_WORD-1:0]  NOISE;
    logic [DATA_WIDTH-1:0] data_out;
    logic                  operation_done;
    logic [1:0]            num_of_errors;
    logic                  busy;

    // Register block side: issues requests, observes results.
    modport master (
        output start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
        input  data_out, operation_done, num_of_errors, busy
    );

    // Core side: consumes requests, produces results.
    modport slave (
        input  start, CTRL, DATA_IN, CODEWORD_WIDTH, NOISE,
        output data_out, operation_done, num_of_errors, busy
    );
endinterface

// File: rtl/ecc_enc_dec_core.sv
// rtl/ecc_enc_dec_core.sv - bit-serial extended Hamming (SECDED) encode / decode / noisy-channel core

module ecc_enc_dec_core #(
    parameter int AMBA_WORD  = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    ecc_enc_dec_core_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ENC,
        S_NOISE,
        S_DEC,
        S_FIX,
        S_DONE
    } state_t;

    localparam logic [1:0] OP_ENC  = 2'd0;
    localparam logic [1:0] OP_DEC  = 2'd1;
    localparam logic [1:0] OP_FULL = 2'd2;
    localparam logic [1:0] OP_NOP  = 2'd3;

    // Hamming positions that are powers of two carry check bits.
    function automatic logic is_pow2(input logic [4:0] p);
        return (p & (p - 5'd1)) == 5'd0;
    endfunction

    // Ones on codeword bits 0..W-1, where wl = W-1.
    function automatic logic [31:0] width_mask(input logic [4:0] wl);
        logic [31:0] m;
        m = '0;
        for (int i = 0; i < 32; i++) begin
            m[i] = (5'(i) <= wl);
        end
        return m;
    endfunction

    // Collect data positions (non-power-of-two, below the parity bit) in ascending order.
    function automatic logic [31:0] extract_data(input logic [31:0] cw, input logic [4:0] wl);
        logic [31:0] d;
        logic [4:0]  k;
        logic [4:0]  idx;
        d = '0;
        k = '0;
        for (int i = 0; i < 31; i++) begin
            idx = 5'(i);
            if ((idx < wl) && !is_pow2(idx + 5'd1)) begin
                d[k] = cw[idx];
                k    = k + 5'd1;
            end
        end
        return d;
    endfunction

    state_t                state_q, state_d;
    logic                  start_d_q, start_d_d;
    logic [1:0]            op_q, op_d;
    logic [4:0]            wl_q, wl_d;
    logic [31:0]           din_q, din_d;
    logic [31:0]           noise_q, noise_d;
    logic [31:0]           cw_q, cw_d;
    logic [4:0]            cnt_q, cnt_d;
    logic [4:0]            dptr_q, dptr_d;
    logic [4:0]            syn_q, syn_d;
    logic                  par_q, par_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
    logic [1:0]            nerr_q, nerr_d;
    logic                  done_q, done_d;

    logic [4:0]            pos;
    logic                  last;
    logic                  bit_v;
    logic [4:0]            wl_new;
    logic [31:0]           cw_fin;
    logic [31:0]           corr;
    logic [31:0]           res;
    logic [1:0]            res_nerr;
    logic                  res_load;

    logic                  unused_in;
    assign unused_in = ^{bus.CTRL[AMBA_WORD-1:2], bus.CODEWORD_WIDTH[AMBA_WORD-1:2]};

    generate
        if (AMBA_WORD > 32) begin : g_wide_word
            logic unused_hi;
            assign unused_hi = ^{bus.DATA_IN[AMBA_WORD-1:32], bus.NOISE[AMBA_WORD-1:32]};
        end
    endgenerate

    // Next-state, serial datapath and result formation.
    always_comb begin
        state_d    = state_q;
        start_d_d  = bus.start;
        op_d       = op_q;
        wl_d       = wl_q;
        din_d      = din_q;
        noise_d    = noise_q;
        cw_d       = cw_q;
        cnt_d      = cnt_q;
        dptr_d     = dptr_q;
        syn_d      = syn_q;
        par_d      = par_q;
        data_out_d = data_out_q;
        nerr_d     = nerr_q;
        done_d     = 1'b0;

        pos      = cnt_q + 5'd1;
        last     = (cnt_q == wl_q);
        bit_v    = 1'b0;
        wl_new   = 5'd31;
        cw_fin   = cw_q;
        corr     = cw_q;
        res      = '0;
        res_nerr = 2'd0;
        res_load = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (bus.start && !start_d_q) begin
                    state_d = S_LOAD;
                end
            end

            S_LOAD: begin
                case (bus.CODEWORD_WIDTH[1:0])
                    2'd0:    wl_new = 5'd7;
                    2'd1:    wl_new = 5'd15;
                    default: wl_new = 5'd31;
                endcase
                op_d    = bus.CTRL[1:0];
                din_d   = bus.DATA_IN[31:0];
                noise_d = bus.NOISE[31:0];
                wl_d    = wl_new;
                cnt_d   = '0;
                dptr_d  = '0;
                syn_d   = '0;
                par_d   = 1'b0;
                case (bus.CTRL[1:0])
                    OP_DEC: begin
                        cw_d    = bus.DATA_IN[31:0] & width_mask(wl_new);
                        state_d = S_DEC;
                    end
                    // No-op goes through FIX so every result is formed in one place.
                    OP_NOP: begin
                        cw_d    = '0;
                        state_d = S_FIX;
                    end
                    default: begin
                        cw_d    = '0;
                        state_d = S_ENC;
                    end
                endcase
            end

            // Data positions are filled one per cycle; the syndrome of the data
            // positions is exactly the check-bit vector, inserted on the last cycle.
            S_ENC: begin
                if (!last) begin
                    if (!is_pow2(pos)) begin
                        bit_v       = din_q[dptr_q];
                        cw_d[cnt_q] = bit_v;
                        if (bit_v) begin
                            syn_d = syn_q ^ pos;
                        end
                        par_d  = par_q ^ bit_v;
                        dptr_d = dptr_q + 5'd1;
                    end
                    cnt_d = cnt_q + 5'd1;
                end else begin
                    cw_fin[0] = syn_q[0];
                    cw_fin[1] = syn_q[1];
                    cw_fin[3] = syn_q[2];
                    if (wl_q >= 5'd15) begin
                        cw_fin[7] = syn_q[3];
                    end
                    if (wl_q == 5'd31) begin
                        cw_fin[15] = syn_q[4];
                    end
                    cw_fin[wl_q] = par_q ^ (^syn_q);
                    cw_d         = cw_fin;
                    if (op_q == OP_FULL) begin
                        state_d = S_NOISE;
                    end else begin
                        state_d  = S_DONE;
                        res      = cw_fin;
                        res_load = 1'b1;
                    end
                end
            end

            S_NOISE: begin
                cw_d    = cw_q ^ (noise_q & width_mask(wl_q));
                cnt_d   = '0;
                syn_d   = '0;
                par_d   = 1'b0;
                state_d = S_DEC;
            end

            // Parity covers every bit; the syndrome excludes the overall-parity bit.
            S_DEC: begin
                bit_v = cw_q[cnt_q];
                par_d = par_q ^ bit_v;
                if (!last && bit_v) begin
                    syn_d = syn_q ^ pos;
                end
                if (last) begin
                    state_d = S_FIX;
                end else begin
                    cnt_d = cnt_q + 5'd1;
                end
            end

            S_FIX: begin
                if (op_q != OP_NOP) begin
                    if (par_q) begin
                        res_nerr = 2'd1;
                        if (syn_q != 5'd0) begin
                            corr[syn_q - 5'd1] = ~cw_q[syn_q - 5'd1];
                        end else begin
                            corr[wl_q] = ~cw_q[wl_q];
                        end
                    end else if (syn_q != 5'd0) begin
                        res_nerr = 2'd2;
                    end
                    res = extract_data(corr, wl_q);
                end
                res_load = 1'b1;
                state_d  = S_DONE;
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (res_load) begin
            data_out_d       = '0;
            data_out_d[31:0] = res;
            nerr_d           = res_nerr;
            done_d           = 1'b1;
        end
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            start_d_q  <= 1'b0;
            op_q       <= '0;
            wl_q       <= '0;
            din_q      <= '0;
            noise_q    <= '0;
            cw_q       <= '0;
            cnt_q      <= '0;
            dptr_q     <= '0;
            syn_q      <= '0;
            par_q      <= 1'b0;
            data_out_q <= '0;
            nerr_q     <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_d_q  <= start_d_d;
            op_q       <= op_d;
            wl_q       <= wl_d;
            din_q      <= din_d;
            noise_q    <= noise_d;
            cw_q       <= cw_d;
            cnt_q      <= cnt_d;
            dptr_q     <= dptr_d;
            syn_q      <= syn_d;
            par_q      <= par_d;
            data_out_q <= data_out_d;
            nerr_q     <= nerr_d;
            done_q     <= done_d;
        end
    end

    assign bus.data_out       = data_out_q;
    assign bus.operation_done = done_q;
    assign bus.num_of_errors  = nerr_q;
    assign bus.busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_ecc_enc_dec_core.sv
// tb/tb_ecc_enc_dec_core.sv - randomized self-checking bench for ecc_enc_dec_core

module tb_ecc_enc_dec_core;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   passes = 0;
    int   done_cnt = 0;

    ecc_enc_dec_core_if #(.AMBA_WORD(32), .DATA_WIDTH(32)) bus ();

    ecc_enc_dec_core #(.AMBA_WORD(32), .DATA_WIDTH(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Count done pulses for the exactly-one / none checks.
    always @(posedge clk) begin
        if (bus.operation_done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic int w_of(input int code);
        return (code == 0) ? 8 : (code == 1) ? 16 : 32;
    endfunction

    function automatic int lat_of(input int op, input int w);
        case (op)
            0:       return w + 1;
            1:       return w + 2;
            2:       return 2 * w + 3;
            default: return 2;
        endcase
    endfunction

    function automatic logic [31:0] m_encode(input logic [31:0] data, input int w);
        logic [31:0] cw;
        logic        par;
        int          k;
        cw = '0;
        k  = 0;
        for (int p = 1; p < w; p++) begin
            if ((p & (p - 1)) != 0) begin
                cw[p-1] = data[k];
                k++;
            end
        end
        for (int j = 0; (1 << j) < w; j++) begin
            par = 1'b0;
            for (int p = 1; p < w; p++) begin
                if (((p & (p - 1)) != 0) && (((p >> j) & 1) == 1)) par ^= cw[p-1];
            end
            cw[(1 << j) - 1] = par;
        end
        par = 1'b0;
        for (int i = 0; i < w - 1; i++) par ^= cw[i];
        cw[w-1] = par;
        return cw;
    endfunction

    task automatic m_decode(input logic [31:0] cw, input int w,
                            output logic [31:0] data, output logic [1:0] ne);
        int          s;
        logic        pp;
        logic [31:0] c;
        int          k;
        s  = 0;
        pp = 1'b0;
        for (int i = 0; i < w; i++) begin
            if (cw[i]) begin
                pp = ~pp;
                if (i < w - 1) s = s ^ (i + 1);
            end
        end
        c = cw;
        if (pp) begin
            ne = 2'd1;
            if (s != 0) c[s-1] = ~c[s-1];
            else        c[w-1] = ~c[w-1];
        end else if (s != 0) begin
            ne = 2'd2;
        end else begin
            ne = 2'd0;
        end
        data = '0;
        k    = 0;
        for (int p = 1; p < w; p++) begin
            if ((p & (p - 1)) != 0) begin
                data[k] = c[p-1];
                k++;
            end
        end
    endtask

    // Issue one operation and wait (bounded) for its done pulse.
    task automatic run_op(input logic [31:0] ctrl, input logic [31:0] din,
                          input logic [31:0] cww, input logic [31:0] noise,
                          input bit scramble,
                          output logic [31:0] res, output logic [1:0] ne, output int lat);
        @(negedge clk);
        bus.CTRL           = ctrl;
        bus.DATA_IN        = din;
        bus.CODEWORD_WIDTH = cww;
        bus.NOISE          = noise;
        bus.start          = 1'b1;
        lat = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (scramble && n == 3) begin
                bus.CTRL           = $urandom;
                bus.DATA_IN        = $urandom;
                bus.CODEWORD_WIDTH = $urandom;
                bus.NOISE          = $urandom;
            end
            if (bus.operation_done === 1'b1) begin
                lat = n - 1;
                break;
            end
        end
        res = bus.data_out;
        ne  = bus.num_of_errors;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        rst                = 1'b0;
        bus.start          = 1'b0;
        bus.CTRL           = '0;
        bus.DATA_IN        = '0;
        bus.CODEWORD_WIDTH = '0;
        bus.NOISE          = '0;
        repeat (3) @(negedge clk);
        checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", bus.busy); else passes++;
        checks++; if (bus.data_out !== 32'd0) $display("FAIL reset_data got %h want 0", bus.data_out); else passes++;
        checks++; if (bus.num_of_errors !== 2'd0) $display("FAIL reset_nerr got %0d want 0", bus.num_of_errors); else passes++;
        checks++; if (bus.operation_done !== 1'b0) $display("FAIL reset_done got %0b want 0", bus.operation_done); else passes++;
        rst = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_vectors();
        logic [31:0] res;
        logic [1:0]  ne;
        int          lat;
        run_op(32'd0, 32'hB, 32'd0, 32'd0, 1'b0, res, ne, lat);
        checks++; if (res !== 32'h55) $display("FAIL enc8_data got %h want 55", res); else passes++;
        checks++; if (ne !== 2'd0) $display("FAIL enc8_nerr got %0d want 0", ne); else passes++;
        checks++; if (lat !== 9) $display("FAIL enc8_lat got %0d want 9", lat); else passes++;
        run_op(32'd2, 32'hB, 32'd0, 32'h04, 1'b0, res, ne, lat);
        checks++; if (res !== 32'hB) $display("FAIL full1_data got %h want b", res); else passes++;
        checks++; if (ne !== 2'd1) $display("FAIL full1_nerr got %0d want 1", ne); else passes++;
        checks++; if (lat !== 19) $display("FAIL full1_lat got %0d want 19", lat); else passes++;
        run_op(32'd2, 32'hB, 32'd0, 32'h05, 1'b0, res, ne, lat);
        checks++; if (res !== 32'hA) $display("FAIL full2_data got %h want a", res); else passes++;
        checks++; if (ne !== 2'd2) $display("FAIL full2_nerr got %0d want 2", ne); else passes++;
        run_op(32'd1, 32'hD5, 32'd0, 32'd0, 1'b0, res, ne, lat);
        checks++; if (res !== 32'hB) $display("FAIL dec_par_data got %h want b", res); else passes++;
        checks++; if (ne !== 2'd1) $display("FAIL dec_par_nerr got %0d want 1", ne); else passes++;
        checks++; if (lat !== 10) $display("FAIL dec_par_lat got %0d want 10", lat); else passes++;
    endtask

    task automatic test_random();
        logic [31:0] data, din, noise, noise_in, ctrl, cww, wm, exp_res, res;
        logic [1:0]  exp_ne, ne;
        int          op, wc, w, lat, nf;
        for (int it = 0; it < 40; it++) begin
            op = $urandom_range(0, 3);
            wc = $urandom_range(0, 3);
            w  = w_of(wc);
            wm = (w == 32) ? 32'hFFFF_FFFF : ((32'd1 << w) - 32'd1);
            data  = $urandom;
            noise = '0;
            nf    = $urandom_range(0, 3);
            for (int f = 0; f < nf; f++) noise[$urandom_range(0, w - 1)] ^= 1'b1;
            if ($urandom_range(0, 4) == 0) noise = $urandom;
            noise_in = noise | ($urandom & ~wm);
            din = data;
            if (op == 1) din = (m_encode(data, w) ^ noise) | ($urandom & ~wm);
            case (op)
                0: begin exp_res = m_encode(data, w); exp_ne = 2'd0; end
                1: m_decode(din & wm, w, exp_res, exp_ne);
                2: m_decode((m_encode(data, w) ^ noise) & wm, w, exp_res, exp_ne);
                default: begin exp_res = '0; exp_ne = 2'd0; end
            endcase
            ctrl = ($urandom & ~32'd3) | 32'(op);
            cww  = ($urandom & ~32'd3) | 32'(wc);
            run_op(ctrl, din, cww, noise_in, (it % 2) == 1, res, ne, lat);
            checks++; if (res !== exp_res) $display("FAIL rand_data it=%0d op=%0d w=%0d got %h want %h", it, op, w, res, exp_res); else passes++;
            checks++; if (ne !== exp_ne) $display("FAIL rand_nerr it=%0d op=%0d w=%0d got %0d want %0d", it, op, w, ne, exp_ne); else passes++;
            checks++; if (lat !== lat_of(op, w)) $display("FAIL rand_lat it=%0d op=%0d w=%0d got %0d want %0d", it, op, w, lat, lat_of(op, w)); else passes++;
        end
    endtask

    task automatic test_second_pulse();
        int d0, lat;
        @(negedge clk);
        bus.CTRL = 32'd0; bus.DATA_IN = 32'h6; bus.CODEWORD_WIDTH = 32'd0; bus.NOISE = 32'd0;
        bus.start = 1'b1;
        d0  = done_cnt;
        lat = -1;
        for (int e = 0; e < 40; e++) begin
            @(posedge clk);
            #1;
            if (bus.operation_done === 1'b1 && lat < 0) lat = e;
            if (e == 0) bus.start = 1'b0;
            if (e == 4) bus.start = 1'b1;
            if (e == 5) bus.start = 1'b0;
        end
        checks++; if (lat !== 9) $display("FAIL pulse2_lat got %0d want 9", lat); else passes++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL pulse2_count got %0d want 1", done_cnt - d0); else passes++;
        checks++; if (bus.data_out !== m_encode(32'h6, 8)) $display("FAIL pulse2_data got %h want %h", bus.data_out, m_encode(32'h6, 8)); else passes++;
    endtask

    task automatic test_reset_mid_op();
        logic [31:0] res, prev;
        logic [1:0]  ne;
        int          d0, lat;
        prev = m_encode(32'h6, 8);
        @(negedge clk);
        bus.CTRL = 32'd0; bus.DATA_IN = 32'h0ABC_1234; bus.CODEWORD_WIDTH = 32'd2; bus.NOISE = 32'd0;
        bus.start = 1'b1;
        d0 = done_cnt;
        for (int e = 0; e < 45; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) bus.start = 1'b0;
            if (e == 4) bus.start = 1'b1;
            if (e == 5) bus.start = 1'b0;
            if (e == 20) begin
                checks++; if (bus.busy !== 1'b1) $display("FAIL rstmid_busy_before got %0b want 1", bus.busy); else passes++;
                checks++; if (bus.data_out !== prev) $display("FAIL rstmid_hold got %h want %h", bus.data_out, prev); else passes++;
                rst = 1'b0;
                #1;
                checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_busy got %0b want 0", bus.busy); else passes++;
                checks++; if (bus.data_out !== 32'd0) $display("FAIL rstmid_data got %h want 0", bus.data_out); else passes++;
                checks++; if (bus.num_of_errors !== 2'd0) $display("FAIL rstmid_nerr got %0d want 0", bus.num_of_errors); else passes++;
            end
            if (e == 23) rst = 1'b1;
        end
        checks++; if (done_cnt - d0 !== 0) $display("FAIL rstmid_nodone got %0d want 0", done_cnt - d0); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL rstmid_idle got %0b want 0", bus.busy); else passes++;
        run_op(32'd0, 32'h0123_4567, 32'd2, 32'd0, 1'b0, res, ne, lat);
        checks++; if (res !== m_encode(32'h0123_4567, 32)) $display("FAIL rstmid_after_data got %h want %h", res, m_encode(32'h0123_4567, 32)); else passes++;
        checks++; if (lat !== 33) $display("FAIL rstmid_after_lat got %0d want 33", lat); else passes++;
    endtask

    task automatic test_hold_start();
        int d0, lat;
        @(negedge clk);
        bus.CTRL = 32'd3; bus.DATA_IN = $urandom; bus.CODEWORD_WIDTH = 32'd1; bus.NOISE = $urandom;
        bus.start = 1'b1;
        d0  = done_cnt;
        lat = -1;
        for (int e = 0; e < 50; e++) begin
            @(posedge clk);
            #1;
            if (bus.operation_done === 1'b1 && lat < 0) lat = e;
        end
        bus.start = 1'b0;
        repeat (5) @(negedge clk);
        checks++; if (lat !== 2) $display("FAIL nop_lat got %0d want 2", lat); else passes++;
        checks++; if (done_cnt - d0 !== 1) $display("FAIL hold_count got %0d want 1", done_cnt - d0); else passes++;
        checks++; if (bus.data_out !== 32'd0) $display("FAIL nop_data got %h want 0", bus.data_out); else passes++;
        checks++; if (bus.num_of_errors !== 2'd0) $display("FAIL nop_nerr got %0d want 0", bus.num_of_errors); else passes++;
    endtask

    task automatic test_back_to_back();
        int d0;
        @(negedge clk);
        bus.CTRL = 32'd3;
        bus.start = 1'b1;
        d0 = done_cnt;
        for (int e = 0; e < 25; e++) begin
            @(posedge clk);
            #1;
            if (e == 0) bus.start = 1'b0;
            if (e == 2) bus.start = 1'b1;
        end
        checks++; if (done_cnt - d0 !== 1) $display("FAIL b2b_count got %0d want 1", done_cnt - d0); else passes++;
        checks++; if (bus.busy !== 1'b0) $display("FAIL b2b_busy got %0b want 0", bus.busy); else passes++;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_vectors();
        test_random();
        test_second_pulse();
        test_reset_mid_op();
        test_hold_start();
        test_back_to_back();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
